// File: rtl/tlm_burst_mem_target.sv
// Burst-capable TLM memory target: valid/ready request, write, read and response channels
// around a byte-strobed word RAM, with a fixed extra read latency.
module tlm_burst_mem_target #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256,
    parameter int LEN_W  = 4,
    parameter int ID_W   = 4,
    parameter int RD_LAT = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_cmd_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [LEN_W-1:0]    req_len_i,
    input  logic [ID_W-1:0]     req_id_i,
    input  logic                wdata_valid_i,
    output logic                wdata_ready_o,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                wlast_i,
    output logic                rdata_valid_o,
    input  logic                rdata_ready_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                rlast_o,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [3:0]          rsp_status_o,
    output logic [ID_W-1:0]     rsp_id_o,
    output logic                busy_o
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [3:0] ST_OK    = 4'h1;
    localparam logic [3:0] ST_ADDR  = 4'hE;
    localparam logic [3:0] ST_CMD   = 4'hD;
    localparam logic [3:0] ST_BURST = 4'hC;

    localparam logic [1:0] CMD_READ    = 2'd0;
    localparam logic [1:0] CMD_WRITE   = 2'd1;
    localparam logic [1:0] CMD_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {IDLE, WRITE, DRAIN, RWAIT, READ, RESP} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   beat_q, beat_d, beat_nx;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [3:0]         wait_q, wait_d;
    logic [3:0]         status_q, status_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [AW-1:0]      index_q, index_d;
    logic [DATA_W-1:0]  rdata_q;
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               we, rd_en;
    logic [AW-1:0]      wr_addr, rd_addr;
    logic [ADDR_W:0]    idx_ext, end_ext;
    logic               addr_bad;

    // One extra bit so that index+len can never wrap back into range.
    assign idx_ext  = {1'b0, req_addr_i} >> OFF;
    assign end_ext  = idx_ext + (ADDR_W+1)'(req_len_i);
    assign addr_bad = (|(req_addr_i & ADDR_W'(BYTES - 1))) ||
                      (end_ext >= (ADDR_W+1)'(DEPTH));
    assign beat_nx  = beat_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        len_d         = len_q;
        wait_d        = wait_q;
        status_d      = status_q;
        id_d          = id_q;
        index_d       = index_q;
        req_ready_o   = 1'b0;
        wdata_ready_o = 1'b0;
        rdata_valid_o = 1'b0;
        rlast_o       = 1'b0;
        rsp_valid_o   = 1'b0;
        busy_o        = 1'b1;
        we            = 1'b0;
        rd_en         = 1'b0;
        wr_addr       = index_q + AW'(beat_q);
        rd_addr       = index_q + AW'(beat_q);
        case (state_q)
            IDLE: begin
                busy_o      = 1'b0;
                req_ready_o = rst_ni;
                if (req_valid_i) begin
                    index_d = idx_ext[AW-1:0];
                    len_d   = req_len_i;
                    id_d    = req_id_i;
                    beat_d  = '0;
                    wait_d  = '0;
                    if (req_cmd_i == CMD_ILLEGAL) begin
                        status_d = ST_CMD;
                        state_d  = RESP;
                    end else if (addr_bad) begin
                        status_d = ST_ADDR;
                        state_d  = (req_cmd_i == CMD_WRITE) ? DRAIN : RESP;
                    end else begin
                        status_d = ST_OK;
                        case (req_cmd_i)
                            CMD_READ:  state_d = RWAIT;
                            CMD_WRITE: state_d = WRITE;
                            default:   state_d = RESP;
                        endcase
                    end
                end
            end
            WRITE: begin
                wdata_ready_o = 1'b1;
                if (wdata_valid_i) begin
                    we = 1'b1;
                    if (beat_q == len_q) begin
                        if (!wlast_i) status_d = ST_BURST;
                        state_d = RESP;
                    end else if (wlast_i) begin
                        status_d = ST_BURST;
                        state_d  = RESP;
                    end else begin
                        beat_d = beat_nx;
                    end
                end
            end
            DRAIN: begin
                wdata_ready_o = 1'b1;
                if (wdata_valid_i) begin
                    if (wlast_i || beat_q == len_q) state_d = RESP;
                    else                            beat_d  = beat_nx;
                end
            end
            RWAIT: begin
                // The last wait cycle launches the registered read of beat 0.
                if (wait_q == 4'(RD_LAT)) begin
                    rd_en   = 1'b1;
                    state_d = READ;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            READ: begin
                rdata_valid_o = 1'b1;
                rlast_o       = (beat_q == len_q);
                if (rdata_ready_i) begin
                    if (beat_q == len_q) begin
                        state_d = RESP;
                    end else begin
                        beat_d  = beat_nx;
                        rd_en   = 1'b1;
                        rd_addr = index_q + AW'(beat_nx);
                    end
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            len_q    <= '0;
            wait_q   <= '0;
            status_q <= '0;
            id_q     <= '0;
            index_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            len_q    <= len_d;
            wait_q   <= wait_d;
            status_q <= status_d;
            id_q     <= id_d;
            index_q  <= index_d;
            if (rd_en) rdata_q <= mem[rd_addr];
        end
    end

    // RAM contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk_i) begin
        if (we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wstrb_i[b]) mem[wr_addr][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o      = rdata_q;
    assign rsp_status_o = status_q;
    assign rsp_id_o     = id_q;

endmodule

// File: tb/tb_tlm_burst_mem_target.sv
// Directed self-checking bench for tlm_burst_mem_target (DEPTH=256, 32-bit data, RD_LAT=2).
module tb_tlm_burst_mem_target;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_cmd = '0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_len = '0;
    logic [3:0]  req_id = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        rdata_valid;
    logic        rdata_ready = 1'b0;
    logic [31:0] rdata;
    logic        rlast;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [3:0]  rsp_status;
    logic [3:0]  rsp_id;
    logic        busy;

    int total = 0;
    int bad = 0;

    tlm_burst_mem_target #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(256), .LEN_W(4), .ID_W(4), .RD_LAT(2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_cmd_i(req_cmd),
        .req_addr_i(req_addr), .req_len_i(req_len), .req_id_i(req_id),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
        .wstrb_i(wstrb), .wlast_i(wlast),
        .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready), .rdata_o(rdata),
        .rlast_o(rlast),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_status_o(rsp_status),
        .rsp_id_o(rsp_id), .busy_o(busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one request and returns just after its accept edge.
    task automatic applyStimulus(input logic [1:0] cmd, input logic [31:0] addr,
                                 input logic [3:0] len, input logic [3:0] id);
        int n = 0;
        req_valid = 1'b1; req_cmd = cmd; req_addr = addr; req_len = len; req_id = id;
        while (!req_ready && n < 50) begin tick(); n++; end
        if (n >= 50) checkOutput("req_ready_timeout", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic writeBeat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        wdata_valid = 1'b1; wdata = data; wstrb = strb; wlast = last;
        while (!wdata_ready && n < 50) begin tick(); n++; end
        if (n >= 50) checkOutput("wdata_ready_timeout", 64'(wdata_ready), 64'd1);
        tick();
        wdata_valid = 1'b0; wlast = 1'b0;
    endtask

    task automatic readBeat(input string tag, input logic [31:0] exp_data, input logic exp_last);
        int n = 0;
        rdata_ready = 1'b1;
        while (!rdata_valid && n < 50) begin tick(); n++; end
        checkOutput({tag, "_valid"}, 64'(rdata_valid), 64'd1);
        checkOutput({tag, "_data"}, 64'(rdata), 64'(exp_data));
        checkOutput({tag, "_last"}, 64'(rlast), 64'(exp_last));
        tick();
        rdata_ready = 1'b0;
    endtask

    task automatic waitResp(input string tag, input logic [3:0] exp_status, input logic [3:0] exp_id);
        int n = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
        checkOutput({tag, "_status"}, 64'(rsp_status), 64'(exp_status));
        checkOutput({tag, "_id"}, 64'(rsp_id), 64'(exp_id));
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        // Reset and idle outputs
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_status", 64'(rsp_status), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        checkOutput("idle_req_ready", 64'(req_ready), 64'd1);
        wdata_valid = 1'b1;
        #1;
        checkOutput("idle_wdata_ready", 64'(wdata_ready), 64'd0);
        wdata_valid = 1'b0;
        tick();

        // Single write, partial-strobe overwrite, read back
        applyStimulus(2'd1, 32'h10, 4'd0, 4'd1);
        writeBeat(32'h11223344, 4'hF, 1'b1);
        waitResp("w1", 4'h1, 4'd1);
        applyStimulus(2'd1, 32'h10, 4'd0, 4'd2);
        writeBeat(32'h000000FF, 4'h1, 1'b1);
        waitResp("w2", 4'h1, 4'd2);
        applyStimulus(2'd0, 32'h10, 4'd0, 4'd3);
        readBeat("r1", 32'h112233FF, 1'b1);
        waitResp("r1", 4'h1, 4'd3);

        // Burst write then stalled burst read with latency check
        applyStimulus(2'd1, 32'h0, 4'd3, 4'd4);
        for (int k = 0; k < 4; k++) writeBeat(32'hA0 + 32'(k), 4'hF, k == 3);
        waitResp("wb", 4'h1, 4'd4);
        applyStimulus(2'd0, 32'h0, 4'd3, 4'd5);
        checkOutput("lat_busy", 64'(busy), 64'd1);
        tick(); checkOutput("lat_c1", 64'(rdata_valid), 64'd0);
        tick(); checkOutput("lat_c2", 64'(rdata_valid), 64'd0);
        tick(); checkOutput("lat_c3", 64'(rdata_valid), 64'd1);
        for (int k = 0; k < 4; k++) begin
            rdata_ready = 1'b0;
            checkOutput("stall_data", 64'(rdata), 64'hA0 + 64'(k));
            tick();
            checkOutput("stall_valid", 64'(rdata_valid), 64'd1);
            checkOutput("stall_hold", 64'(rdata), 64'hA0 + 64'(k));
            checkOutput("stall_last", 64'(rlast), 64'(k == 3));
            rdata_ready = 1'b1;
            tick();
        end
        rdata_ready = 1'b0;
        waitResp("rb", 4'h1, 4'd5);

        // Address errors: past end of RAM and misaligned
        applyStimulus(2'd0, 32'h3F8, 4'd3, 4'd6);
        checkOutput("aerr_no_rdata", 64'(rdata_valid), 64'd0);
        waitResp("aerr1", 4'hE, 4'd6);
        applyStimulus(2'd0, 32'h2, 4'd0, 4'd7);
        waitResp("aerr2", 4'hE, 4'd7);

        // Last word of RAM is in range
        applyStimulus(2'd1, 32'h3FC, 4'd0, 4'd8);
        writeBeat(32'hCAFEF00D, 4'hF, 1'b1);
        waitResp("wtop", 4'h1, 4'd8);
        applyStimulus(2'd0, 32'h3FC, 4'd0, 4'd9);
        readBeat("rtop", 32'hCAFEF00D, 1'b1);
        waitResp("rtop", 4'h1, 4'd9);

        // Errored write is drained without touching RAM
        applyStimulus(2'd1, 32'h3F8, 4'd0, 4'd1);
        writeBeat(32'h00005A5A, 4'hF, 1'b1);
        waitResp("w5a", 4'h1, 4'd1);
        applyStimulus(2'd1, 32'h3F8, 4'd3, 4'd2);
        writeBeat(32'hDEADBEEF, 4'hF, 1'b0);
        writeBeat(32'hDEADBEEF, 4'hF, 1'b1);
        waitResp("drain", 4'hE, 4'd2);
        applyStimulus(2'd0, 32'h3F8, 4'd0, 4'd3);
        readBeat("r5a", 32'h00005A5A, 1'b1);
        waitResp("r5a", 4'h1, 4'd3);

        // Early wlast: beats 0-1 written, 2-3 untouched
        applyStimulus(2'd1, 32'h0, 4'd3, 4'd10);
        writeBeat(32'hB0, 4'hF, 1'b0);
        writeBeat(32'hB1, 4'hF, 1'b1);
        waitResp("early", 4'hC, 4'd10);
        applyStimulus(2'd0, 32'h0, 4'd3, 4'd11);
        readBeat("re0", 32'hB0, 1'b0);
        readBeat("re1", 32'hB1, 1'b0);
        readBeat("re2", 32'hA2, 1'b0);
        readBeat("re3", 32'hA3, 1'b1);
        waitResp("re", 4'h1, 4'd11);

        // Missing wlast on final beat: written, but burst error
        applyStimulus(2'd1, 32'h20, 4'd1, 4'd12);
        writeBeat(32'hD0, 4'hF, 1'b0);
        writeBeat(32'hD1, 4'hF, 1'b0);
        waitResp("nolast", 4'hC, 4'd12);
        applyStimulus(2'd0, 32'h20, 4'd1, 4'd13);
        readBeat("rn0", 32'hD0, 1'b0);
        readBeat("rn1", 32'hD1, 1'b1);
        waitResp("rn", 4'h1, 4'd13);

        // Illegal command answered next cycle; response held under backpressure
        applyStimulus(2'd3, 32'h10, 4'd0, 4'd7);
        checkOutput("cmd_rsp_now", 64'(rsp_valid), 64'd1);
        checkOutput("cmd_status_now", 64'(rsp_status), 64'hD);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("hold_valid", 64'(rsp_valid), 64'd1);
            checkOutput("hold_status", 64'(rsp_status), 64'hD);
            checkOutput("hold_id", 64'(rsp_id), 64'd7);
        end
        waitResp("cmd", 4'hD, 4'd7);

        // IGNORE leaves RAM untouched
        applyStimulus(2'd2, 32'h10, 4'd0, 4'd14);
        checkOutput("ign_wready", 64'(wdata_ready), 64'd0);
        waitResp("ign", 4'h1, 4'd14);
        applyStimulus(2'd0, 32'h10, 4'd0, 4'd15);
        readBeat("rign", 32'h112233FF, 1'b1);
        waitResp("rign", 4'h1, 4'd15);

        // Reset in the middle of a long read
        applyStimulus(2'd1, 32'h40, 4'd7, 4'd1);
        for (int k = 0; k < 8; k++) writeBeat(32'hC0 + 32'(k), 4'hF, k == 7);
        waitResp("wc", 4'h1, 4'd1);
        applyStimulus(2'd0, 32'h40, 4'd7, 4'd2);
        readBeat("rc0", 32'hC0, 1'b0);
        readBeat("rc1", 32'hC1, 1'b0);
        checkOutput("rc2_pre", 64'(rdata), 64'hC2);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 64'(rdata_valid), 64'd0);
        checkOutput("mid_rst_rdata", 64'(rdata), 64'd0);
        checkOutput("mid_rst_busy", 64'(busy), 64'd0);
        checkOutput("mid_rst_rsp", 64'(rsp_valid), 64'd0);
        checkOutput("mid_rst_status", 64'(rsp_status), 64'd0);
        checkOutput("mid_rst_ready", 64'(req_ready), 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_rsp", 64'(rsp_valid), 64'd0);
        applyStimulus(2'd0, 32'h40, 4'd7, 4'd3);
        for (int k = 0; k < 8; k++) readBeat("rcp", 32'hC0 + 32'(k), k == 7);
        waitResp("rcp", 4'h1, 4'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
